// File: rtl/cpu16_pkg.sv
// cpu16_pkg: opcode constants, instruction field positions, FSM state type and
// the ALU-op classifier shared by the cpu16 top and its ALU.
// Optional feature macro: CPU16_EXT_ALU_EN (adds OR/XOR/NOT ALU opcodes).
package cpu16_pkg;

    localparam int unsigned WIDTH = 16;

    // Instruction field positions
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_RSH = 4'h2;
    localparam logic [3:0] OP_LSH = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BR  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_IMM = 4'hC;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    // True for opcodes whose result comes from the ALU and which update Z
    function automatic logic is_alu_op(input logic [3:0] op);
        logic hit;
        hit = (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSH) ||
              (op == OP_LSH) || (op == OP_AND);
`ifdef CPU16_EXT_ALU_EN
        hit = hit || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/cpu16_alu.sv
// cpu16_alu: combinational ALU for cpu16. Shifts are logical and use only the
// low four bits of b. OR/XOR/NOT exist only when CPU16_EXT_ALU_EN is defined.
module cpu16_alu
    import cpu16_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        zero
);

    // Operation select; non-ALU opcodes yield zero and are ignored upstream
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_RSH: result = a >> b[3:0];
            OP_LSH: result = a << b[3:0];
            OP_AND: result = a & b;
`ifdef CPU16_EXT_ALU_EN
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
`endif
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cpu16.sv
// cpu16: 16-bit, 3-cycle-per-instruction CPU (FETCH -> DECODE -> EXEC).
// Separate instruction port (ia/id) and data port (da/dd/rw); dd is driven
// only while rw=0. Optional macro CPU16_EXT_ALU_EN enables OR/XOR/NOT.
module cpu16
    import cpu16_pkg::*;
(
    input  logic        ck,
    input  logic        rst,
    output logic [15:0] ia,
    input  logic [15:0] id,
    output logic [15:0] da,
    inout  logic [15:0] dd,
    output logic        rw
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        z;
    logic [15:0] regs [16];

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  imm;
    logic [15:0] rs1_val;
    logic [15:0] rs2_val;

    logic [15:0] alu_res;
    logic        alu_zero;

    logic        wb_en;
    logic [15:0] wb_data;
    logic        z_en;
    logic [15:0] pc_nxt;

    assign op      = ir[OP_MSB:OP_LSB];
    assign rd      = ir[RD_MSB:RD_LSB];
    assign rs1     = ir[RS1_MSB:RS1_LSB];
    assign rs2     = ir[RS2_MSB:RS2_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];

    assign ia = pc;
    assign dd = rw ? 'z : rs1_val;

    cpu16_alu u_alu (
        .op     (op),
        .a      (rs1_val),
        .b      (rs2_val),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // FSM state register
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM sequencing: fixed three-step cycle, no stalls
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // EXEC result selection: register write-back, Z update and next PC
    always_comb begin
        wb_en   = 1'b0;
        wb_data = '0;
        z_en    = 1'b0;
        pc_nxt  = pc + 16'd1;
        if (is_alu_op(op)) begin
            wb_en   = 1'b1;
            wb_data = alu_res;
            z_en    = 1'b1;
        end else begin
            case (op)
                OP_LD: begin
                    wb_en   = 1'b1;
                    wb_data = dd;
                end
                OP_IMM: begin
                    wb_en   = 1'b1;
                    wb_data = {8'h00, imm};
                end
                OP_JMP: pc_nxt = rs2_val;
                OP_BR: begin
                    if (z) begin
                        pc_nxt = rs2_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural state: IR capture, data-port setup, write-back and PC
    always_ff @(posedge ck) begin
        if (rst) begin
            pc   <= '0;
            ir   <= '0;
            z    <= 1'b0;
            da   <= '0;
            rw   <= 1'b1;
            regs <= '{default: '0};
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= id;
                end
                S_DECODE: begin
                    da <= rs2_val;
                    rw <= (op != OP_ST);
                end
                S_EXEC: begin
                    rw <= 1'b1;
                    pc <= pc_nxt;
                    if (wb_en) begin
                        regs[rd] <= wb_data;
                    end
                    if (z_en) begin
                        z <= alu_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu16.sv
// tb_cpu16: self-checking bench for cpu16. Directed programs exercise reset,
// arithmetic/Z, branches, shifts, PC wrap, reset abort and NOPs; a random
// phase runs instruction-by-instruction against an ISA-level model.
module tb_cpu16;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, RSH = 4'h2, LSH = 4'h3;
    localparam logic [3:0] AND = 4'h5, JMP = 4'h8, BR = 4'h9, ST = 4'hA;
    localparam logic [3:0] LD = 4'hB;
    localparam logic [15:0] NOP = 16'hD000;

    logic        ck  = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ia;
    logic [15:0] id;
    logic [15:0] da;
    wire  [15:0] dd;
    logic        rw;

    logic [15:0] imem [65536];
    logic [15:0] dmem [65536];
    int          wr_count = 0;

    // ISA-level model state
    logic [15:0] mr [16];
    logic [15:0] mdmem [65536];
    logic [15:0] mpc;
    logic        mz;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    assign id = imem[ia];
    assign dd = (rw === 1'b1) ? dmem[da] : 16'hzzzz;

    cpu16 dut (
        .ck  (ck),
        .rst (rst),
        .ia  (ia),
        .id  (id),
        .da  (da),
        .dd  (dd),
        .rw  (rw)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] s1, input logic [3:0] s2);
        return {op, rd, s1, s2};
    endfunction

    function automatic logic [15:0] immw(input logic [3:0] rd, input logic [7:0] v);
        return {4'hC, rd, v};
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge ck);
        #1 rst = 1'b0;
    endtask

    task automatic run_instrs(input int n);
        repeat (3 * n) @(posedge ck);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            imem[i] = NOP;
            dmem[i] = '0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = '0;
        mpc = '0;
        mz  = 1'b0;
    endtask

    // One instruction, computed from the ISA rules with plain arithmetic
    task automatic model_exec(input logic [15:0] w);
        logic [3:0]  op;
        logic [3:0]  rd;
        int unsigned a;
        int unsigned b;
        int unsigned r;
        logic        alu;
        logic [15:0] npc;
        op  = w[15:12];
        rd  = w[11:8];
        a   = mr[w[7:4]];
        b   = mr[w[3:0]];
        r   = 0;
        alu = 1'b0;
        npc = mpc + 16'd1;
        case (op)
            4'h0: begin r = (a + b) % 65536; alu = 1'b1; end
            4'h1: begin r = (a + 65536 - b) % 65536; alu = 1'b1; end
            4'h2: begin r = a / (1 << (b % 16)); alu = 1'b1; end
            4'h3: begin r = (a * (1 << (b % 16))) % 65536; alu = 1'b1; end
            4'h5: begin r = a & b; alu = 1'b1; end
`ifdef CPU16_EXT_ALU_EN
            4'h4: begin r = a | b; alu = 1'b1; end
            4'h6: begin r = a ^ b; alu = 1'b1; end
            4'h7: begin r = 65535 - a; alu = 1'b1; end
`endif
            4'h8: npc = b[15:0];
            4'h9: if (mz) npc = b[15:0];
            4'hA: mdmem[b] = a[15:0];
            4'hB: mr[rd] = mdmem[b];
            4'hC: mr[rd] = {8'h00, w[7:0]};
            default: ;
        endcase
        if (alu) begin
            mr[rd] = r[15:0];
            mz     = (r == 0);
        end
        mpc = npc;
    endtask

    task automatic test_reset();
        clear_mem();
        dmem[0] = 16'h1234;
        do_reset(5);
        checks++; if (ia !== 16'h0000) begin errors++; $display("FAIL reset_ia: got %h expected 0000", ia); end
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b expected 1", rw); end
        checks++; if (da !== 16'h0000) begin errors++; $display("FAIL reset_da: got %h expected 0000", da); end
        checks++; if (dd !== 16'h1234) begin errors++; $display("FAIL reset_dd_released: got %h expected 1234", dd); end
        run_instrs(1);
        checks++; if (ia !== 16'h0001) begin errors++; $display("FAIL reset_second_fetch: got %h expected 0001", ia); end
    endtask

    task automatic test_multiply();
        logic        found;
        logic [15:0] prod;
        clear_mem();
        dmem[0] = 16'd5;
        dmem[1] = 16'd15;
        prod = dmem[0] * dmem[1];
        imem[0]  = immw(0, 8'd0);
        imem[1]  = enc(LD, 1, 0, 0);
        imem[2]  = immw(3, 8'd1);
        imem[3]  = enc(LD, 2, 0, 3);
        imem[4]  = immw(4, 8'd0);
        imem[5]  = immw(5, 8'd1);
        imem[6]  = immw(7, 8'd9);
        imem[7]  = immw(8, 8'd16);
        imem[8]  = immw(10, 8'd12);
        imem[9]  = enc(AND, 9, 2, 5);
        imem[10] = enc(BR, 0, 0, 10);
        imem[11] = enc(ADD, 4, 4, 1);
        imem[12] = enc(LSH, 1, 1, 5);
        imem[13] = enc(RSH, 2, 2, 5);
        imem[14] = enc(BR, 0, 0, 8);
        imem[15] = enc(JMP, 0, 0, 7);
        imem[16] = immw(11, 8'd2);
        imem[17] = enc(SUB, 6, 6, 6);
        imem[18] = immw(12, 8'd20);
        imem[19] = enc(ST, 0, 4, 11);
        imem[20] = enc(JMP, 0, 0, 12);
        do_reset(5);
        found = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge ck);
            if (rw === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mul_store_seen: no write within 600 cycles, expected one");
        end else begin
            checks++; if (da !== 16'd2) begin errors++; $display("FAIL mul_da: got %h expected 0002", da); end
            checks++; if (dd !== prod) begin errors++; $display("FAIL mul_dd: got %0d expected %0d", dd, prod); end
        end
    endtask

    task automatic test_alu_branch();
        clear_mem();
        imem[0]  = immw(1, 8'hFF);
        imem[1]  = immw(2, 8'h01);
        imem[2]  = enc(ADD, 3, 1, 2);
        imem[3]  = immw(5, 8'h20);
        imem[4]  = enc(BR, 0, 0, 5);
        imem[5]  = enc(SUB, 4, 2, 2);
        imem[6]  = immw(6, 8'h40);
        imem[7]  = enc(ST, 0, 3, 6);
        imem[8]  = immw(7, 8'h41);
        imem[9]  = enc(ST, 0, 4, 7);
        imem[10] = enc(BR, 0, 0, 5);
        dmem[16'h41] = 16'hFFFF;
        do_reset(5);
        run_instrs(5);
        checks++; if (ia !== 16'h0005) begin errors++; $display("FAIL br_not_taken_ia: got %h expected 0005", ia); end
        run_instrs(6);
        checks++; if (ia !== 16'h0020) begin errors++; $display("FAIL br_taken_ia: got %h expected 0020", ia); end
        checks++; if (dmem[16'h40] !== 16'h0100) begin errors++; $display("FAIL add_result: got %h expected 0100", dmem[16'h40]); end
        checks++; if (dmem[16'h41] !== 16'h0000) begin errors++; $display("FAIL sub_result: got %h expected 0000", dmem[16'h41]); end
    endtask

    task automatic test_shift();
        clear_mem();
        imem[0] = immw(1, 8'h80);
        imem[1] = immw(3, 8'h11);
        imem[2] = enc(LSH, 2, 1, 3);
        imem[3] = immw(4, 8'd8);
        imem[4] = enc(LSH, 6, 1, 4);
        imem[5] = enc(RSH, 5, 6, 4);
        imem[6] = immw(7, 8'h50);
        imem[7] = enc(ST, 0, 2, 7);
        imem[8] = immw(7, 8'h51);
        imem[9] = enc(ST, 0, 5, 7);
        do_reset(5);
        run_instrs(10);
        checks++; if (dmem[16'h50] !== 16'h0100) begin errors++; $display("FAIL lsh_masked: got %h expected 0100", dmem[16'h50]); end
        checks++; if (dmem[16'h51] !== 16'h0080) begin errors++; $display("FAIL rsh_8: got %h expected 0080", dmem[16'h51]); end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        imem[0] = immw(1, 8'hFF);
        imem[1] = immw(4, 8'd8);
        imem[2] = enc(LSH, 1, 1, 4);
        imem[3] = immw(2, 8'hFF);
        imem[4] = enc(ADD, 1, 1, 2);
        imem[5] = enc(JMP, 0, 0, 1);
        do_reset(5);
        run_instrs(6);
        checks++; if (ia !== 16'hFFFF) begin errors++; $display("FAIL jmp_ffff: got %h expected ffff", ia); end
        run_instrs(1);
        checks++; if (ia !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h expected 0000", ia); end
    endtask

    task automatic test_abort_nop();
        int w0;
        clear_mem();
        dmem[16'h10] = 16'hAAAA;
        imem[0] = immw(1, 8'h55);
        imem[1] = immw(2, 8'h10);
        imem[2] = enc(ST, 0, 1, 2);
        do_reset(5);
        w0 = wr_count;
        run_instrs(2);
        @(posedge ck); #1;
        // Reset is sampled on the edge that would otherwise start the store's EXEC
        rst = 1'b1;
        @(posedge ck); #1;
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL abort_rw: got %b expected 1", rw); end
        checks++; if (ia !== 16'h0000) begin errors++; $display("FAIL abort_ia: got %h expected 0000", ia); end
        imem[0]  = immw(1, 8'h07);
        imem[1]  = immw(2, 8'h30);
        imem[2]  = enc(SUB, 3, 3, 3);
        imem[3]  = 16'hE112;
        imem[4]  = immw(5, 8'h20);
        imem[5]  = enc(BR, 0, 0, 5);
        imem[16'h20] = enc(ST, 0, 1, 2);
        @(posedge ck); #1;
        rst = 1'b0;
        run_instrs(4);
        checks++; if (ia !== 16'h0004) begin errors++; $display("FAIL nop_pc: got %h expected 0004", ia); end
        run_instrs(2);
        checks++; if (ia !== 16'h0020) begin errors++; $display("FAIL nop_keeps_z: got %h expected 0020", ia); end
        run_instrs(1);
        checks++; if (dmem[16'h30] !== 16'h0007) begin errors++; $display("FAIL nop_keeps_reg: got %h expected 0007", dmem[16'h30]); end
        checks++; if (dmem[16'h10] !== 16'hAAAA) begin errors++; $display("FAIL abort_mem: got %h expected aaaa", dmem[16'h10]); end
        checks++; if (wr_count !== w0 + 1) begin errors++; $display("FAIL abort_writes: got %0d expected %0d", wr_count - w0, 1); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [15:0] v;
        logic [3:0]  op;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 65536; i++) begin
                w = 16'($urandom);
                if ($urandom_range(3) == 0) w[15:12] = ST;
                imem[i] = w;
                v = 16'($urandom);
                dmem[i]  = v;
                mdmem[i] = v;
            end
            do_reset(3);
            model_reset();
            for (int n = 0; n < 250; n++) begin
                w  = imem[mpc];
                op = w[15:12];
                checks++;
                if (ia !== mpc) begin
                    errors++;
                    $display("FAIL rnd_ia: got %h expected %h", ia, mpc);
                    break;
                end
                @(posedge ck); #1;
                @(posedge ck); #1;
                checks++;
                if (rw !== (op != ST)) begin errors++; $display("FAIL rnd_rw: got %b expected %b", rw, (op != ST)); end
                if (op == ST || op == LD) begin
                    checks++;
                    if (da !== mr[w[3:0]]) begin errors++; $display("FAIL rnd_da: got %h expected %h", da, mr[w[3:0]]); end
                end
                if (op == ST) begin
                    checks++;
                    if (dd !== mr[w[7:4]]) begin errors++; $display("FAIL rnd_dd: got %h expected %h", dd, mr[w[7:4]]); end
                end
                model_exec(w);
                @(posedge ck); #1;
            end
        end
    endtask

    initial begin
        do_reset(2);
        fork
            forever begin
                @(negedge ck);
                if (rw === 1'b0) begin
                    dmem[da] = dd;
                    wr_count++;
                end
            end
        join_none
        test_reset();
        test_multiply();
        test_alu_branch();
        test_shift();
        test_pc_wrap();
        test_abort_nop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
